// File: rtl/lab3_cache_mem_responder.sv
// Main-memory responder for the cache memory port: word array with byte-lane access,
// fixed-latency response pipeline and an in-order response FIFO that absorbs back-pressure.
module lab3_cache_mem_responder #(
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [76:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [46:0] memresp_msg,
  output logic        err
);

  localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
  localparam int unsigned OCC_W   = $clog2(RESP_DEPTH + 1);
  localparam int unsigned FIFO_AW = $clog2(RESP_DEPTH);

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } resp_t;

  req_t  req;
  logic  req_fire;
  logic  resp_fire;

  logic [IDX_W-1:0] idx;
  logic [4:0]       sh_amt;
  logic [3:0]       rd_be;
  logic [3:0]       wr_be;
  logic [31:0]      rd_mask;
  logic [31:0]      wr_mask;
  logic [31:0]      cur_word;
  logic [31:0]      wr_word;
  logic [31:0]      rd_data;
  logic             is_write;
  logic             is_amo;
  resp_t            resp_in;

  logic [31:0] mem [NUM_WORDS];

  logic  push_vld;
  resp_t push_msg;

  resp_t              fifo [RESP_DEPTH];
  logic [OCC_W-1:0]   fifo_cnt;
  logic [FIFO_AW-1:0] wr_slot;
  logic [OCC_W-1:0]   occ;

  // Address bits above the array index are intentionally ignored (address wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req.addr[31:IDX_W+2];

  assign req        = memreq_msg;
  assign req_fire   = memreq_val && memreq_rdy;
  assign resp_fire  = memresp_val && memresp_rdy;
  assign memreq_rdy = (occ < OCC_W'(RESP_DEPTH)) && !reset;

  // Request decode: byte lanes, merged write word and aligned read data.
  always_comb begin
    rd_mask  = '0;
    wr_mask  = '0;
    idx      = req.addr[2 +: IDX_W];
    sh_amt   = (req.len == 2'd0) ? 5'd0 : {req.addr[1:0], 3'b000};
    rd_be    = (req.len == 2'd0) ? 4'hf : 4'((5'd1 << req.len) - 5'd1);
    // Lanes shifted past byte 3 fall off the top of the word.
    wr_be    = (req.len == 2'd0) ? 4'hf : (rd_be << req.addr[1:0]);
    for (int b = 0; b < 4; b++) begin
      rd_mask[8*b +: 8] = {8{rd_be[b]}};
      wr_mask[8*b +: 8] = {8{wr_be[b]}};
    end
    cur_word = mem[idx];
    wr_word  = (cur_word & ~wr_mask) | ((req.data << sh_amt) & wr_mask);
    rd_data  = (cur_word >> sh_amt) & rd_mask;
    is_write = (req.typ == TYPE_WRITE) || (req.typ == TYPE_INIT);
    is_amo   = !is_write && (req.typ != TYPE_READ);

    resp_in        = '0;
    resp_in.typ    = req.typ;
    resp_in.opaque = req.opaque;
    resp_in.test   = 2'b00;
    resp_in.len    = req.len;
    resp_in.data   = is_write ? 32'd0 : rd_data;
  end

  // Backing array, deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (req_fire && is_write) begin
      mem[idx] <= wr_word;
    end
  end

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign push_vld = req_fire;
      assign push_msg = resp_in;
    end else begin : g_pipe
      logic [LATENCY-2:0] stg_vld;
      resp_t              stg_msg [LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stg_vld <= '0;
        end else begin
          stg_vld[0] <= req_fire;
          for (int i = 1; i < int'(LATENCY) - 1; i++) begin
            stg_vld[i] <= stg_vld[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        stg_msg[0] <= resp_in;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          stg_msg[i] <= stg_msg[i-1];
        end
      end

      assign push_vld = stg_vld[LATENCY-2];
      assign push_msg = stg_msg[LATENCY-2];
    end
  endgenerate

  // Shift-down FIFO: entry 0 is always the head, so outputs come straight from flops.
  assign wr_slot = FIFO_AW'(fifo_cnt - OCC_W'(resp_fire));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_cnt <= '0;
      for (int i = 0; i < int'(RESP_DEPTH); i++) begin
        fifo[i] <= '0;
      end
    end else begin
      if (resp_fire) begin
        for (int i = 0; i < int'(RESP_DEPTH) - 1; i++) begin
          fifo[i] <= fifo[i+1];
        end
        fifo[RESP_DEPTH-1] <= '0;
      end
      if (push_vld) begin
        fifo[wr_slot] <= push_msg;
      end
      fifo_cnt <= fifo_cnt + OCC_W'(push_vld) - OCC_W'(resp_fire);
    end
  end

  assign memresp_val = (fifo_cnt != '0);
  assign memresp_msg = fifo[0];

  // Outstanding count covers pipeline plus FIFO, which guarantees FIFO space on push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(req_fire) - OCC_W'(resp_fire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (req_fire && is_amo) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Scoreboard bench for lab3_cache_mem_responder: directed requests push expected responses,
// an independent monitor pops and checks content and arrival cycle.
module tb_lab3_cache_mem_responder;

  localparam int LAT = 2;

  localparam logic [2:0] T_READ  = 3'd0;
  localparam logic [2:0] T_WRITE = 3'd1;
  localparam logic [2:0] T_INIT  = 3'd2;
  localparam logic [2:0] T_AMO   = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [76:0] memreq_msg;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [46:0] memresp_msg;
  logic        err;

  typedef struct {
    logic [46:0] msg;
    int          due;
    bit          exact;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  lab3_cache_mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                         input logic [31:0] a, input logic [1:0] l,
                                         input logic [31:0] d);
    return {t, o, a, l, d};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                          input logic [1:0] l, input logic [31:0] d);
    return {t, o, 2'b00, l, d};
  endfunction

  function automatic logic [31:0] wval(input int i);
    return 32'hA5C3_0000 | 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every response handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && memresp_val && memresp_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got %h expected none at cycle %0d", memresp_msg, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (memresp_msg !== mon_e.msg) begin
          bad++;
          $display("FAIL resp_msg: got %h expected %h", memresp_msg, mon_e.msg);
        end
        total++;
        if (mon_e.exact ? (cyc != mon_e.due) : (cyc < mon_e.due)) begin
          bad++;
          $display("FAIL resp_latency: got cycle %0d expected %s%0d", cyc,
                   mon_e.exact ? "" : ">=", mon_e.due);
        end
      end
    end
  end

  task automatic send(input logic [76:0] r, input logic [46:0] e, input bit exact,
                      output int waited);
    int w;
    memreq_msg = r;
    memreq_val = 1'b1;
    for (w = 0; w < 40; w++) begin
      @(negedge clk);
      if (memreq_rdy) break;
      @(posedge clk);
      #1;
    end
    waited = w;
    if (w >= 40) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got no memreq_rdy expected accept within 40 cycles");
    end else begin
      exp_q.push_back('{msg: e, due: cyc + LAT, exact: exact});
      @(posedge clk);
      #1;
    end
    memreq_val = 1'b0;
  endtask

  task automatic txn(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                     input logic [1:0] l, input logic [31:0] d, input logic [31:0] exp_d,
                     input bit exact, output int waited);
    send(mk_req(t, o, a, l, d), mk_resp(t, o, l, exp_d), exact, waited);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    reset       = 1'b1;
    memreq_val  = 1'b0;
    memreq_msg  = '0;
    memresp_rdy = 1'b1;

    @(negedge clk);
    check("rst_req_rdy", 64'(memreq_rdy), 64'd0);
    check("rst_resp_val", 64'(memresp_val), 64'd0);
    check("rst_resp_msg", 64'(memresp_msg), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", 64'(memreq_rdy), 64'd1);
    @(posedge clk);
    #1;

    // INIT then READ, exact latency
    txn(T_INIT, 8'h05, 32'h100, 2'd0, 32'hdeadbeef, 32'h0, 1'b1, w);
    txn(T_READ, 8'h3c, 32'h100, 2'd0, 32'h0, 32'hdeadbeef, 1'b1, w);
    drain();

    // Back-to-back stream: INIT 16 words, then READ them back
    for (int i = 0; i < 16; i++) begin
      txn(T_INIT, 8'(i), 32'h40 + 32'(4 * i), 2'd0, wval(i), 32'h0, 1'b1, w);
      check("stream_init_rdy", 64'(w), 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      txn(T_READ, 8'h80 + 8'(i), 32'h40 + 32'(4 * i), 2'd0, 32'h0, wval(i), 1'b1, w);
      check("stream_read_rdy", 64'(w), 64'd0);
    end
    drain();

    // Back-pressure: only RESP_DEPTH requests accepted
    memresp_rdy = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      memreq_val = 1'b1;
      memreq_msg = mk_req(T_READ, 8'h90 + 8'(n), 32'h40 + 32'(4 * n), 2'd0, 32'h0);
      @(negedge clk);
      if (memreq_rdy) begin
        exp_q.push_back('{msg: mk_resp(T_READ, 8'h90 + 8'(n), 2'd0, wval(n)),
                          due: cyc + LAT, exact: 1'b0});
        n++;
      end
      @(posedge clk);
      #1;
    end
    memreq_val = 1'b0;
    check("bp_accepted", 64'(n), 64'd4);
    @(negedge clk);
    check("bp_rdy_low", 64'(memreq_rdy), 64'd0);
    check("bp_head_val", 64'(memresp_val), 64'd1);
    check("bp_head_msg", 64'(memresp_msg), 64'(mk_resp(T_READ, 8'h90, 2'd0, wval(0))));
    @(posedge clk);
    #1 memresp_rdy = 1'b1;
    @(negedge clk);
    check("bp_rdy_fire_cycle", 64'(memreq_rdy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_recover", 64'(memreq_rdy), 64'd1);
    drain();

    // Subword write and reads
    txn(T_INIT,  8'h20, 32'h200, 2'd0, 32'h11223344, 32'h0, 1'b1, w);
    txn(T_WRITE, 8'h21, 32'h201, 2'd1, 32'h000000AB, 32'h0, 1'b1, w);
    txn(T_READ,  8'h22, 32'h200, 2'd0, 32'h0, 32'h1122AB44, 1'b1, w);
    txn(T_READ,  8'h23, 32'h201, 2'd1, 32'h0, 32'h000000AB, 1'b1, w);
    txn(T_READ,  8'h24, 32'h202, 2'd2, 32'h0, 32'h00001122, 1'b1, w);
    txn(T_READ,  8'h25, 32'h203, 2'd3, 32'h0, 32'h00000011, 1'b1, w);
    drain();

    // Address wrap
    txn(T_WRITE, 8'h30, 32'h400, 2'd0, 32'hcafef00d, 32'h0, 1'b1, w);
    txn(T_READ,  8'h31, 32'h000, 2'd0, 32'h0, 32'hcafef00d, 1'b1, w);
    drain();

    // Reset with responses outstanding
    memresp_rdy = 1'b0;
    txn(T_READ, 8'h40, 32'h100, 2'd0, 32'h0, 32'hdeadbeef, 1'b0, w);
    txn(T_READ, 8'h41, 32'h200, 2'd0, 32'h0, 32'h1122AB44, 1'b0, w);
    txn(T_READ, 8'h42, 32'h000, 2'd0, 32'h0, 32'hcafef00d, 1'b0, w);
    @(negedge clk);
    check("pre_reset_val", 64'(memresp_val), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_reset_val", 64'(memresp_val), 64'd0);
    check("mid_reset_rdy", 64'(memreq_rdy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    memresp_rdy = 1'b1;
    @(negedge clk);
    check("post_reset_val", 64'(memresp_val), 64'd0);
    check("post_reset_err", 64'(err), 64'd0);
    repeat (10) @(posedge clk);
    #1;

    // AMO: read-like response, err sticky, array untouched
    txn(T_INIT, 8'h50, 32'h300, 2'd0, 32'h55667788, 32'h0, 1'b1, w);
    txn(T_AMO,  8'h77, 32'h300, 2'd0, 32'hffffffff, 32'h55667788, 1'b1, w);
    drain();
    @(negedge clk);
    check("amo_err_set", 64'(err), 64'd1);
    @(posedge clk);
    #1;
    txn(T_READ, 8'h51, 32'h300, 2'd0, 32'h0, 32'h55667788, 1'b1, w);
    drain();
    @(negedge clk);
    check("amo_err_sticky", 64'(err), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("err_cleared", 64'(err), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
